// File: rtl/eth_rst_seq.sv
// SFP bring-up and Ethernet reset sequencer.
// Conditions the raw SFP pins, sequences eth_rst / tx_disable and drives the status LEDs.
module eth_rst_seq #(
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 256,
    parameter int unsigned TXEN_DELAY      = 64,
    parameter int unsigned HB_BIT          = 26
) (
    input  logic       clk100,
    input  logic       sys_rst,
    input  logic       sfp_clk_alarm_b,
    input  logic       eth0_tx_fault,
    input  logic       eth0_rx_los,
    output logic       eth_rst,
    output logic       eth_tx_disable,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] led
);

    localparam int unsigned NIN     = 3;
    localparam int unsigned DW      = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = ((HOLD_CYCLES > TXEN_DELAY) ? HOLD_CYCLES : TXEN_DELAY) - 1;
    localparam int unsigned TW      = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
    localparam int unsigned HBW     = HB_BIT + 1;
    // bit 0 = clk_ok, bit 1 = tx_fault, bit 2 = rx_los; pessimistic at reset
    localparam logic [NIN-1:0] IN_RST = 3'b110;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_CLK = 3'd1,
        ST_TX_EN    = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    logic [NIN-1:0]         sync1_q, sync1_d;
    logic [NIN-1:0]         sync2_q, sync2_d;
    logic [NIN-1:0]         db_q, db_d;
    logic [NIN-1:0][DW-1:0] db_cnt_q, db_cnt_d;
    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             retry_q, retry_d;
    logic [HBW-1:0]         hb_q, hb_d;
    logic                   eth_rst_q, eth_rst_d;
    logic                   tx_dis_q, tx_dis_d;
    logic                   link_q, link_d;
    logic                   clk_ok, fault;

    assign clk_ok = db_q[0];
    assign fault  = db_q[1];

    // Input conditioning: two-flop synchronizer feeding a stable-count debouncer.
    always_comb begin
        sync1_d = {eth0_rx_los, eth0_tx_fault, sfp_clk_alarm_b};
        sync2_d = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Sequencer next state; clock loss always wins over fault.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = (timer_q == TW'(TMR_MAX)) ? timer_q : timer_q + TW'(1);
        hb_d    = hb_q + HBW'(1);
        case (state_q)
            ST_HOLD: begin
                if (timer_q == TW'(HOLD_CYCLES - 1)) state_d = ST_WAIT_CLK;
            end
            ST_WAIT_CLK: begin
                if (clk_ok) state_d = ST_TX_EN;
            end
            ST_TX_EN: begin
                if (!clk_ok)                              state_d = ST_HOLD;
                else if (timer_q == TW'(TXEN_DELAY - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!clk_ok) begin
                    state_d = ST_HOLD;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end else if (fault) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (!clk_ok)                                           state_d = ST_HOLD;
                else if (timer_q >= TW'(HOLD_CYCLES - 1) && !fault)    state_d = ST_TX_EN;
            end
            default: state_d = ST_HOLD;
        endcase
        if (state_d != state_q) timer_d = '0;

        eth_rst_d = (state_d == ST_HOLD) || (state_d == ST_WAIT_CLK);
        tx_dis_d  = (state_d != ST_RUN);
        link_d    = (state_d == ST_RUN) && !db_d[2];
    end

    always_ff @(posedge clk100 or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q   <= IN_RST;
            sync2_q   <= IN_RST;
            db_q      <= IN_RST;
            db_cnt_q  <= '0;
            state_q   <= ST_HOLD;
            timer_q   <= '0;
            retry_q   <= '0;
            hb_q      <= '0;
            eth_rst_q <= 1'b1;
            tx_dis_q  <= 1'b1;
            link_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            hb_q      <= hb_d;
            eth_rst_q <= eth_rst_d;
            tx_dis_q  <= tx_dis_d;
            link_q    <= link_d;
        end
    end

    assign eth_rst        = eth_rst_q;
    assign eth_tx_disable = tx_dis_q;
    assign link_up        = link_q;
    assign state          = state_q;
    assign retry_cnt      = retry_q;
    assign led            = {hb_q[HB_BIT], link_q, db_q[2], db_q[1], retry_q[3:0]};

endmodule

// File: tb/tb_eth_rst_seq.sv
// Bench for eth_rst_seq: per-cycle comparison against a behavioural model plus directed timing checks.
module tb_eth_rst_seq;

    localparam int unsigned HOLD = 64;
    localparam int unsigned DEB  = 16;
    localparam int unsigned TXEN = 8;
    localparam int unsigned HB   = 6;
    localparam int S_HOLD = 0, S_WAIT = 1, S_TXEN = 2, S_RUN = 3, S_FAULT = 4;

    logic       clk100 = 1'b0;
    logic       sys_rst = 1'b1;
    logic       sfp_clk_alarm_b = 1'b1;
    logic       eth0_tx_fault = 1'b0;
    logic       eth0_rx_los = 1'b0;
    logic       eth_rst, eth_tx_disable, link_up;
    logic [2:0] state;
    logic [7:0] retry_cnt, led;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk100 = ~clk100;

    eth_rst_seq #(
        .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(DEB), .TXEN_DELAY(TXEN), .HB_BIT(HB)
    ) dut (
        .clk100(clk100), .sys_rst(sys_rst),
        .sfp_clk_alarm_b(sfp_clk_alarm_b), .eth0_tx_fault(eth0_tx_fault), .eth0_rx_los(eth0_rx_los),
        .eth_rst(eth_rst), .eth_tx_disable(eth_tx_disable), .link_up(link_up),
        .state(state), .retry_cnt(retry_cnt), .led(led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = clock ok, 1 = tx fault, 2 = loss of signal.
    bit          m_s1[3], m_s2[3], m_db[3];
    int          m_run[3];
    int          m_st, m_age, m_retry;
    logic [63:0] m_hb;

    always @(posedge clk100 or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = (i != 0); m_s2[i] = (i != 0); m_db[i] = (i != 0); m_run[i] = 0;
            end
            m_st = S_HOLD; m_age = 0; m_retry = 0; m_hb = '0;
        end else begin
            bit raw[3];
            bit ok, flt;
            int nxt;
            raw[0] = sfp_clk_alarm_b; raw[1] = eth0_tx_fault; raw[2] = eth0_rx_los;
            ok = m_db[0]; flt = m_db[1];
            for (int i = 0; i < 3; i++) begin
                // debounced value follows once the synced value has disagreed DEB cycles running
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
                end else m_run[i] = 0;
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_age++;
            nxt = m_st;
            case (m_st)
                S_HOLD:  if (m_age >= HOLD) nxt = S_WAIT;
                S_WAIT:  if (ok) nxt = S_TXEN;
                S_TXEN:  if (!ok) nxt = S_HOLD; else if (m_age >= TXEN) nxt = S_RUN;
                S_RUN:   if (!ok) begin nxt = S_HOLD; if (m_retry < 255) m_retry++; end
                         else if (flt) nxt = S_FAULT;
                S_FAULT: if (!ok) nxt = S_HOLD; else if (m_age >= HOLD && !flt) nxt = S_TXEN;
                default: nxt = S_HOLD;
            endcase
            if (nxt != m_st) m_age = 0;
            m_st = nxt;
            m_hb = m_hb + 64'd1;
        end
    end

    always @(negedge clk100) begin
        bit         e_rst, e_txd, e_link;
        logic [7:0] e_led;
        e_rst  = (m_st == S_HOLD) || (m_st == S_WAIT);
        e_txd  = (m_st != S_RUN);
        e_link = (m_st == S_RUN) && !m_db[2];
        e_led  = {m_hb[HB], e_link, m_db[2], m_db[1], 4'(m_retry)};
        check("model_state", 32'(state), 32'(m_st));
        check("model_eth_rst", 32'(eth_rst), 32'(e_rst));
        check("model_tx_disable", 32'(eth_tx_disable), 32'(e_txd));
        check("model_link_up", 32'(link_up), 32'(e_link));
        check("model_retry", 32'(retry_cnt), 32'(m_retry));
        check("model_led", 32'(led), 32'(e_led));
    end

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(state);
            1:       return int'(eth_rst);
            2:       return int'(eth_tx_disable);
            default: return int'(link_up);
        endcase
    endfunction

    // Waits (bounded) for a DUT output to reach a value; returns elapsed negedges.
    task automatic wait_for(input string name, input int sel, input int val, input int bound,
                            output int cyc, output bit tmo);
        cyc = 0;
        while (sig(sel) != val && cyc < bound) begin
            @(negedge clk100);
            cyc++;
        end
        tmo = (sig(sel) != val);
        if (tmo) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got %0d required %0d", name, cyc, sig(sel), val);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(S_HOLD));
        check({tag, "_eth_rst"}, 32'(eth_rst), 32'd1);
        check({tag, "_tx_disable"}, 32'(eth_tx_disable), 32'd1);
        check({tag, "_link_up"}, 32'(link_up), 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        check({tag, "_led"}, 32'(led), 32'h30);
    endtask

    initial begin
        int cyc, cyc2;
        bit tmo;
        repeat (3) @(negedge clk100);
        check_reset_values("reset");

        // Bring-up: eth_rst falls HOLD+1 cycles after release, tx_disable TXEN later.
        sys_rst = 1'b0;
        wait_for("bringup_eth_rst", 1, 0, 300, cyc, tmo);
        check("bringup_rst_cycles", 32'(cyc), 32'(HOLD + 1));
        wait_for("bringup_tx_dis", 2, 0, 100, cyc, tmo);
        check("bringup_txen_cycles", 32'(cyc), 32'(TXEN));
        check("bringup_state", 32'(state), 32'(S_RUN));
        check("bringup_link", 32'(link_up), 32'd1);

        // Short alarm glitch is filtered.
        sfp_clk_alarm_b = 1'b0;
        repeat (10) @(negedge clk100);
        sfp_clk_alarm_b = 1'b1;
        repeat (40) @(negedge clk100);
        check("glitch_state", 32'(state), 32'(S_RUN));
        check("glitch_retry", 32'(retry_cnt), 32'd0);

        // Sustained clock loss: HOLD after 2+DEB sync/debounce cycles plus one decision cycle.
        sfp_clk_alarm_b = 1'b0;
        wait_for("clkloss_hold", 0, S_HOLD, 100, cyc, tmo);
        check("clkloss_cycles", 32'(cyc), 32'(DEB + 3));
        check("clkloss_retry", 32'(retry_cnt), 32'd1);
        repeat (12) @(negedge clk100);
        sfp_clk_alarm_b = 1'b1;
        wait_for("clkloss_reentry", 0, S_RUN, 400, cyc, tmo);

        // TX fault: FAULT keeps eth_rst low and lasts exactly HOLD cycles.
        eth0_tx_fault = 1'b1;
        wait_for("fault_enter", 0, S_FAULT, 100, cyc, tmo);
        check("fault_enter_cycles", 32'(cyc), 32'(DEB + 3));
        check("fault_eth_rst", 32'(eth_rst), 32'd0);
        check("fault_tx_dis", 32'(eth_tx_disable), 32'd1);
        repeat (50 - (DEB + 3)) @(negedge clk100);
        eth0_tx_fault = 1'b0;
        wait_for("fault_exit", 0, S_TXEN, 200, cyc2, tmo);
        check("fault_dwell", 32'(50 - (DEB + 3) + cyc2), 32'(HOLD));
        wait_for("fault_run", 0, S_RUN, 100, cyc, tmo);
        check("fault_txen_cycles", 32'(cyc), 32'(TXEN));

        // LOS only gates link_up.
        eth0_rx_los = 1'b1;
        wait_for("los_down", 3, 0, 100, cyc, tmo);
        check("los_down_cycles", 32'(cyc), 32'(DEB + 2));
        check("los_state", 32'(state), 32'(S_RUN));
        eth0_rx_los = 1'b0;
        wait_for("los_up", 3, 1, 100, cyc, tmo);
        check("los_up_cycles", 32'(cyc), 32'(DEB + 2));

        // Enough clock losses to saturate retry_cnt.
        for (int i = 0; i < 256; i++) begin
            sfp_clk_alarm_b = 1'b0;
            wait_for("sat_hold", 0, S_HOLD, 100, cyc, tmo);
            sfp_clk_alarm_b = 1'b1;
            if (tmo) break;
            wait_for("sat_run", 0, S_RUN, 400, cyc, tmo);
            if (tmo) break;
        end
        check("sat_retry", 32'(retry_cnt), 32'd255);
        check("sat_led_low", 32'(led[3:0]), 32'hF);

        // Asynchronous reset in the middle of TX_EN.
        sfp_clk_alarm_b = 1'b0;
        wait_for("mid_hold", 0, S_HOLD, 100, cyc, tmo);
        sfp_clk_alarm_b = 1'b1;
        wait_for("mid_txen", 0, S_TXEN, 400, cyc, tmo);
        repeat (3) @(negedge clk100);
        #2 sys_rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk100);
        sys_rst = 1'b0;
        wait_for("restart_eth_rst", 1, 0, 300, cyc, tmo);
        check("restart_rst_cycles", 32'(cyc), 32'(HOLD + 1));
        wait_for("restart_run", 0, S_RUN, 100, cyc, tmo);
        repeat (5) @(negedge clk100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rst_seq.md
# eth_rst_seq

Reset and SFP bring-up sequencer between the board-level clock/reset logic and the Ethernet core. It synchronizes and debounces the SFP status pins (clock alarm, TX fault, RX LOS) and holds the Ethernet core in reset until the SFP reference clock is stable. It then enables the laser and re-sequences automatically on clock loss or TX fault. It also drives the board LED status byte.

## Interface
Parameters:
- HOLD_CYCLES, 1024: minimum cycles spent in HOLD and in FAULT.
- DEBOUNCE_CYCLES, 256: consecutive stable cycles required before a debounced input changes.
- TXEN_DELAY, 64: cycles between `eth_rst` release and `eth_tx_disable` deassertion.
- HB_BIT, 26: free-running counter bit used for the heartbeat LED.

Ports (clock and reset first):
- clk100  in  1  system clock; the block has one clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- sfp_clk_alarm_b  in  1  raw SFP clock alarm, active-low; 1 means the clock is OK.
- eth0_tx_fault  in  1  raw SFP TX fault, active-high.
- eth0_rx_los  in  1  raw SFP loss of signal, active-high.
- eth_rst  out  1  reset to the Ethernet core, active-high.
- eth_tx_disable  out  1  drives ETH0_TX_DISABLE.
- link_up  out  1  1 when in RUN and debounced LOS is 0.
- state  out  3  current state: HOLD=0, WAIT_CLK=1, TX_EN=2, RUN=3, FAULT=4.
- retry_cnt  out  8  count of RUN→HOLD transitions, saturating at 255.
- led  out  8  {heartbeat, link_up, los_db, fault_db, retry_cnt[3:0]}.

## Operation
Input conditioning:
- Each raw input passes through a two-flop synchronizer, then a debouncer.
- Debouncer: its counter clears whenever the synchronized value equals the debounced value. When they differ, the counter increments. When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value and the counter clears.
- Reset values are pessimistic: clk_ok_db=0, fault_db=1, los_db=1.

State machine (state register, one shared timer):
- HOLD: `eth_rst`=1, `eth_tx_disable`=1. After HOLD_CYCLES cycles in HOLD → WAIT_CLK.
- WAIT_CLK: `eth_rst`=1, `eth_tx_disable`=1. When clk_ok_db=1 → TX_EN.
- TX_EN: `eth_rst`=0, `eth_tx_disable`=1. After TXEN_DELAY cycles → RUN.
- RUN: `eth_rst`=0, `eth_tx_disable`=0.
  - clk_ok_db=0 → HOLD, and retry_cnt increments (saturating).
  - Otherwise, fault_db=1 → FAULT.
- FAULT: `eth_rst`=0, `eth_tx_disable`=1. When at least HOLD_CYCLES cycles have elapsed in FAULT and fault_db=0 → TX_EN.

Transition rules:
- clk_ok_db=0 in TX_EN or FAULT → HOLD. retry_cnt does not increment for these.
- Clock loss has priority over fault in every state.
- The timer clears on every state entry.
- Outputs are a pure decode of the state register, so they are glitch-free and change one cycle after the transition decision.

Other outputs:
- heartbeat = bit HB_BIT of a free-running counter that is cleared by reset.
- rx_los has no effect on sequencing; it only gates `link_up`.

## Timing
- Reset values:
  - state=HOLD, `eth_rst`=1, `eth_tx_disable`=1, `link_up`=0, retry_cnt=0.
  - led=8'b0011_0000 (los_db=1, fault_db=1).
  - All counters and timers 0.
- Input latency: a raw edge held stable from cycle 0 appears in the debounced value at cycle 2+DEBOUNCE_CYCLES.
- Input glitch: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no debounced change.
- Bring-up, with clk_ok_db already 1:
  - `eth_rst` falls HOLD_CYCLES+1 cycles after reset release.
  - `eth_tx_disable` falls TXEN_DELAY cycles after `eth_rst` falls.
- Simultaneous clock loss and fault in RUN → HOLD, and retry_cnt increments.
- Saturation: retry_cnt stays at 255 on further clock losses.
- Reset mid-operation: asserting `sys_rst` in any state forces all reset values asynchronously, within the same cycle.

## Test plan
- Reset, alarm_b=1, fault=0, los=0 → `eth_rst` stays 1 through DEBOUNCE/HOLD and falls at cycle max(HOLD_CYCLES, 2+DEBOUNCE_CYCLES)+1 (±1). `eth_tx_disable` falls 64 cycles later, then `link_up`=1 and state=3.
- In RUN, pulse alarm_b low for 100 cycles → no state change. Hold it low for 300 cycles → state=0 and retry_cnt=1, and re-entry occurs once alarm_b returns high.
- In RUN, assert tx_fault → state=4 and `eth_tx_disable`=1 with `eth_rst` remaining 0. Deassert it after 50 cycles → state=2 only after 1024 cycles in FAULT, then RUN.
- In RUN, toggle rx_los: set to 1 → `link_up`=0 after 258 cycles, with state still 3. Clear it → `link_up`=1 again.
- Force 256 clock-loss cycles → retry_cnt=255 and led[3:0]=4'hF.
- Assert `sys_rst` mid-TX_EN → outputs return to their reset values immediately, and the full sequence restarts after release.
